// File: rtl/result_reader_pkg.sv
// Shared constants for the result reader: default word width, row packing width
// and the output FSM state encoding.
package result_reader_pkg;

  localparam int DW_DEFAULT = 20;
  localparam int ROW_W      = 4 * DW_DEFAULT + 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Row layout is {col_idx, MU1, MU2, MU3, MU4}
  function automatic int row_width(input int dw);
    return 4 * dw + 2;
  endfunction

endpackage

// File: rtl/result_reader_row_fifo.sv
// Row buffer for the result reader: DEPTH packed rows with occupancy tracking.
// A push into a full buffer is accepted only when the head is popped in the same cycle.
module row_fifo
  import result_reader_pkg::*;
#(
  parameter int RW    = ROW_W,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [RW-1:0] din,
  output logic [RW-1:0] dout,
  output logic          full,
  output logic          accept,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (AW + 1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign accept = push && !rst && (!full || do_pop);
  assign dout   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy decides what is valid, and the
  // reader gates outputs so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/result_reader.sv
// Buffers MAC result rows and serializes them as one DW-bit word per handshake,
// MU1 first, tagged with column and element index.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] MU1,
  input  logic [DW-1:0] MU2,
  input  logic [DW-1:0] MU3,
  input  logic [DW-1:0] MU4,
  input  logic [1:0]    col_idx,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_col,
  output logic [1:0]    out_elem,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          full,
  output logic          overflow
);

  localparam int RW = row_width(DW);
  localparam int AW = $clog2(DEPTH);

  logic [0:0]    state;
  logic [0:0]    next_state;
  logic [1:0]    elem;
  logic [RW-1:0] head;
  logic [DW-1:0] word;
  logic [AW:0]   count;
  logic          accept;
  logic          hs;
  logic          pop;

  row_fifo #(.RW(RW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (wr_en),
    .pop    (pop),
    .din    ({col_idx, MU1, MU2, MU3, MU4}),
    .dout   (head),
    .full   (full),
    .accept (accept),
    .count  (count)
  );

  // out_valid comes straight from the state flop, so it never sees out_ready
  assign out_valid = (state == SEND);
  assign hs        = out_valid && out_ready;
  assign pop       = hs && (elem == 2'd3);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SEND;
      SEND:    if (pop && count == {{AW{1'b0}}, 1'b1} && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    word = '0;
    case (elem)
      2'd0:    word = head[4*DW-1 -: DW];
      2'd1:    word = head[3*DW-1 -: DW];
      2'd2:    word = head[2*DW-1 -: DW];
      default: word = head[DW-1 -: DW];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      elem     <= 2'd0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      if (hs) elem <= elem + 2'd1;  // 3 -> 0 on the popping handshake
      if (wr_en && !accept) overflow <= 1'b1;
    end
  end

  assign out_data = out_valid ? word : '0;
  assign out_col  = out_valid ? head[RW-1 -: 2] : 2'd0;
  assign out_elem = elem;
  assign out_last = out_valid && (elem == 2'd3);

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: a scoreboard queue receives the four expected
// words of each accepted row and is popped on every output handshake.
module tb_result_reader;

  localparam int DW = 20;

  typedef struct {
    logic [1:0]    col;
    logic [1:0]    elem;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] mu1, mu2, mu3, mu4;
  logic [1:0]    col_idx;
  logic [DW-1:0] out_data;
  logic [1:0]    out_col;
  logic [1:0]    out_elem;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          full;
  logic          overflow;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  result_reader #(.DW(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .MU1       (mu1),
    .MU2       (mu2),
    .MU3       (mu3),
    .MU4       (mu4),
    .col_idx   (col_idx),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_elem  (out_elem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a row on the write strobe; rows expected to be accepted go to the scoreboard.
  task automatic push_row(input logic [1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3, input bit keep);
    wr_en = 1'b1; col_idx = c; mu1 = a; mu2 = b; mu3 = d2; mu4 = d3;
    if (keep) begin
      sb.push_back('{col: c, elem: 2'd0, data: a});
      sb.push_back('{col: c, elem: 2'd1, data: b});
      sb.push_back('{col: c, elem: 2'd2, data: d2});
      sb.push_back('{col: c, elem: 2'd3, data: d3});
    end
  endtask

  // One clock: compare any handshake at the falling edge, then return #1 after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_col",  32'(out_col),  32'(e.col));
        check("out_elem", 32'(out_elem), 32'(e.elem));
        check("out_last", 32'(out_last), 32'(e.elem == 2'd3));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0;
    step(); step();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    wr_en = 1'b0; out_ready = 1'b0; col_idx = '0;
    mu1 = '0; mu2 = '0; mu3 = '0; mu4 = '0;

    // Reset values
    do_reset();
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_last",     32'(out_last),  32'd0);
    check("rst_full",     32'(full),      32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_data",     32'(out_data),  32'd0);
    check("rst_col",      32'(out_col),   32'd0);
    check("rst_elem",     32'(out_elem),  32'd0);

    // Single row, latency 1, out_last on the fourth word only
    out_ready = 1'b1;
    push_row(2'd2, 20'd1, 20'd2, 20'd3, 20'd4, 1'b1);
    step();
    wr_en = 1'b0;
    check("single_latency", 32'(out_valid), 32'd1);
    repeat (4) step();
    check("single_idle", 32'(out_valid), 32'd0);

    // Backpressure held at element 1
    push_row(2'd1, 20'd10, 20'd20, 20'd30, 20'd40, 1'b1);
    step();
    wr_en = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'd20);
      check("bp_elem",  32'(out_elem),  32'd1);
      check("bp_col",   32'(out_col),   32'd1);
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    check("bp_idle", 32'(out_valid), 32'd0);

    // Overflow: fifth row with no drain is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_row(2'(i), 20'(16 * i + 1), 20'(16 * i + 2), 20'(16 * i + 3), 20'(16 * i + 4), 1'b1);
      step();
    end
    check("ovf_full_after4", 32'(full), 32'd1);
    check("ovf_clear_before5", 32'(overflow), 32'd0);
    push_row(2'd3, 20'hFFFFF, 20'hEEEEE, 20'hDDDDD, 20'hCCCCC, 1'b0);
    step();
    wr_en = 1'b0;
    check("ovf_set",  32'(overflow), 32'd1);
    check("ovf_full", 32'(full),     32'd1);
    out_ready = 1'b1;
    repeat (16) step();
    check("ovf_drained_valid", 32'(out_valid), 32'd0);
    check("ovf_drained_full",  32'(full),      32'd0);
    check("ovf_sticky",        32'(overflow),  32'd1);
    check("ovf_sb_empty",      32'(sb.size()), 32'd0);

    // Push on the same cycle as the elem-3 pop of a full buffer
    do_reset();
    check("pp_rst_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_row(2'(3 - i), 20'(256 + i), 20'(512 + i), 20'(768 + i), 20'(1024 + i), 1'b1);
      step();
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("pp_at_elem3", 32'(out_elem), 32'd3);
    push_row(2'd2, 20'hABCDE, 20'h12345, 20'h0F0F0, 20'hF0F0F, 1'b1);
    step();
    wr_en = 1'b0;
    check("pp_full",     32'(full),     32'd1);
    check("pp_overflow", 32'(overflow), 32'd0);
    repeat (16) step();
    check("pp_drained", 32'(out_valid), 32'd0);
    check("pp_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back rows stream without a bubble
    out_ready = 1'b1;
    push_row(2'd0, 20'hA0, 20'hA1, 20'hA2, 20'hA3, 1'b1);
    step();
    push_row(2'd1, 20'hB0, 20'hB1, 20'hB2, 20'hB3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", 32'(out_valid), 32'd1);
      step();
      wr_en = 1'b0;
    end
    check("b2b_idle", 32'(out_valid), 32'd0);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while element 2 is on the bus; wr_en during reset is ignored
    push_row(2'd3, 20'h11, 20'h22, 20'h33, 20'h44, 1'b1);
    step();
    wr_en = 1'b0;
    step(); step();
    check("mid_at_elem2", 32'(out_elem), 32'd2);
    rst = 1'b1;
    push_row(2'd1, 20'h55, 20'h66, 20'h77, 20'h88, 1'b0);
    step();
    rst = 1'b0; wr_en = 1'b0;
    sb.delete();
    check("mid_valid",    32'(out_valid), 32'd0);
    check("mid_full",     32'(full),      32'd0);
    check("mid_overflow", 32'(overflow),  32'd0);
    check("mid_elem",     32'(out_elem),  32'd0);
    step();
    check("mid_ignored_push", 32'(out_valid), 32'd0);
    push_row(2'd2, 20'd1, 20'd2, 20'd3, 20'd4, 1'b1);
    step();
    wr_en = 1'b0;
    check("mid_again_latency", 32'(out_valid), 32'd1);
    repeat (4) step();
    check("mid_again_idle", 32'(out_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
